// File: rtl/onedconv_layer_executor_if.sv
// Handshake bundle between the 1D-conv scheduler/engine/writer side (master)
// and the layer executor (slave).
interface onedconv_layer_executor_if #(
  parameter int TILE_W = 5
) ();
  logic              start;
  logic [3:0]        layer_id;
  logic              engine_done;
  logic              drain_ack;
  logic              tile_start;
  logic [TILE_W-1:0] tile_idx;
  logic              drain_req;
  logic              busy;
  logic [3:0]        active_layer;
  logic              layer_complete;
  logic              err_invalid;
  logic              err_timeout;

  modport master (
    output start, layer_id, engine_done, drain_ack,
    input  tile_start, tile_idx, drain_req, busy, active_layer,
           layer_complete, err_invalid, err_timeout
  );

  modport slave (
    input  start, layer_id, engine_done, drain_ack,
    output tile_start, tile_idx, drain_req, busy, active_layer,
           layer_complete, err_invalid, err_timeout
  );
endinterface

// File: rtl/onedconv_layer_executor.sv
// 1D-conv layer executor: walks a layer's hardcoded tiles (start/engine/drain).
// Optional watchdog compiled in with `define ONEDCONV_EXEC_WATCHDOG_EN.
module onedconv_layer_executor #(
  parameter int TILE_W     = 5,
  parameter int NUM_LAYERS = 9,
  parameter int WDT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  onedconv_layer_executor_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TILE_START,
    S_TILE_WAIT,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_e;

  if (WDT_CYCLES < 1 || NUM_LAYERS > 16) begin : g_bad_cfg
    $error("onedconv_layer_executor: WDT_CYCLES must be >= 1 and NUM_LAYERS <= 16");
  end

  function automatic logic [TILE_W-1:0] tiles_for(input logic [3:0] id);
    logic [TILE_W-1:0] n;
    case (id)
      4'd0, 4'd1, 4'd7: n = TILE_W'(4);
      4'd2, 4'd3, 4'd6: n = TILE_W'(8);
      4'd4, 4'd5:       n = TILE_W'(16);
      default:          n = TILE_W'(2);
    endcase
    return n;
  endfunction

  state_e            state_q, state_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] tiles_total_q, tiles_total_d;
  logic [3:0]        active_layer_q, active_layer_d;
  logic              tile_start_q, tile_start_d;
  logic              drain_req_q, drain_req_d;
  logic              busy_q, busy_d;
  logic              layer_complete_q, layer_complete_d;
  logic              err_invalid_q, err_invalid_d;
  logic              layer_valid;

`ifdef ONEDCONV_EXEC_WATCHDOG_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             err_timeout_q, err_timeout_d;
`endif

  assign layer_valid = (int'(bus.layer_id) < NUM_LAYERS);

  always_comb begin
    state_d        = state_q;
    tile_idx_d     = tile_idx_q;
    tiles_total_d  = tiles_total_q;
    active_layer_d = active_layer_q;
    err_invalid_d  = 1'b0;
`ifdef ONEDCONV_EXEC_WATCHDOG_EN
    err_timeout_d  = err_timeout_q;
    wdt_cnt_d      = wdt_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (layer_valid) begin
            active_layer_d = bus.layer_id;
            tiles_total_d  = tiles_for(bus.layer_id);
            tile_idx_d     = '0;
            state_d        = S_TILE_START;
`ifdef ONEDCONV_EXEC_WATCHDOG_EN
            err_timeout_d  = 1'b0;
`endif
          end else begin
            err_invalid_d = 1'b1;
          end
        end
      end
      S_TILE_START: state_d = S_TILE_WAIT;
      S_TILE_WAIT:  if (bus.engine_done) state_d = S_DRAIN;
      S_DRAIN:      if (bus.drain_ack) state_d = S_NEXT;
      S_NEXT: begin
        if (tile_idx_q == tiles_total_q - TILE_W'(1)) begin
          state_d = S_DONE;
        end else begin
          tile_idx_d = tile_idx_q + TILE_W'(1);
          state_d    = S_TILE_START;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef ONEDCONV_EXEC_WATCHDOG_EN
    // Counter restarts on every state change, so entering TILE_WAIT or DRAIN
    // sees zero; a stalled wait aborts to IDLE on its WDT_CYCLES-th cycle.
    if (state_d != state_q) begin
      wdt_cnt_d = '0;
    end else if (state_q == S_TILE_WAIT || state_q == S_DRAIN) begin
      if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
        wdt_cnt_d     = '0;
        err_timeout_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
    end
`endif

    // Outputs decoded from the next state so the registered copies track state_q.
    tile_start_d     = (state_d == S_TILE_START);
    drain_req_d      = (state_d == S_DRAIN);
    busy_d           = (state_d != S_IDLE);
    layer_complete_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      tile_idx_q       <= '0;
      tiles_total_q    <= '0;
      active_layer_q   <= '0;
      tile_start_q     <= 1'b0;
      drain_req_q      <= 1'b0;
      busy_q           <= 1'b0;
      layer_complete_q <= 1'b0;
      err_invalid_q    <= 1'b0;
`ifdef ONEDCONV_EXEC_WATCHDOG_EN
      wdt_cnt_q        <= '0;
      err_timeout_q    <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      tile_idx_q       <= tile_idx_d;
      tiles_total_q    <= tiles_total_d;
      active_layer_q   <= active_layer_d;
      tile_start_q     <= tile_start_d;
      drain_req_q      <= drain_req_d;
      busy_q           <= busy_d;
      layer_complete_q <= layer_complete_d;
      err_invalid_q    <= err_invalid_d;
`ifdef ONEDCONV_EXEC_WATCHDOG_EN
      wdt_cnt_q        <= wdt_cnt_d;
      err_timeout_q    <= err_timeout_d;
`endif
    end
  end

  assign bus.tile_start     = tile_start_q;
  assign bus.tile_idx       = tile_idx_q;
  assign bus.drain_req      = drain_req_q;
  assign bus.busy           = busy_q;
  assign bus.active_layer   = active_layer_q;
  assign bus.layer_complete = layer_complete_q;
  assign bus.err_invalid    = err_invalid_q;
`ifdef ONEDCONV_EXEC_WATCHDOG_EN
  assign bus.err_timeout    = err_timeout_q;
`else
  assign bus.err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_onedconv_layer_executor.sv
// Directed bench for onedconv_layer_executor: tile sequencing, latency,
// invalid ids, ignored spurious inputs, mid-layer reset, optional watchdog.
module tb_onedconv_layer_executor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  onedconv_layer_executor_if #(.TILE_W(5)) bus ();

  onedconv_layer_executor #(
    .TILE_W     (5),
    .NUM_LAYERS (9),
    .WDT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: event history sampled on the falling edge.
  int cyc = 0;
  int ts_idx[$];
  int ts_cyc[$];
  int dr_rises = 0;
  int lc_cnt = 0;
  int lc_cyc = 0;
  int ei_cnt = 0;
  bit dr_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.tile_start) begin
      ts_idx.push_back(int'(bus.tile_idx));
      ts_cyc.push_back(cyc);
    end
    if (bus.drain_req && !dr_prev) dr_rises = dr_rises + 1;
    dr_prev = bus.drain_req;
    if (bus.layer_complete) begin
      lc_cnt = lc_cnt + 1;
      lc_cyc = cyc;
    end
    if (bus.err_invalid) ei_cnt = ei_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [3:0] id);
    bus.start    = 1'b1;
    bus.layer_id = id;
    step();
    bus.start    = 1'b0;
  endtask

  // Responder: engine_done ed_delay cycles after tile_start (0 = never),
  // drain_ack on drain_req (or held high), optional spurious injections.
  task automatic serve(input int ed_delay, input bit ack_hold, input bit spur,
                       input int stop_idx, input int max_cyc, output bit got_lc);
    int since;
    since  = -1;
    got_lc = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      bus.engine_done = 1'b0;
      bus.drain_ack   = ack_hold;
      bus.start       = 1'b0;
      if (bus.tile_start) begin
        if (stop_idx >= 0 && int'(bus.tile_idx) == stop_idx) begin
          bus.drain_ack = 1'b0;
          return;
        end
        since = 0;
        if (spur) begin
          bus.engine_done = 1'b1;
          bus.drain_ack   = 1'b1;
          bus.start       = 1'b1;
          bus.layer_id    = 4'd12;
        end
      end else if (since >= 0) begin
        since++;
      end
      if (ed_delay > 0 && since == ed_delay) begin
        bus.engine_done = 1'b1;
        since = -1;
      end
      if (bus.drain_req) begin
        bus.drain_ack = 1'b1;
        if (spur) bus.engine_done = 1'b1;
      end
      if (bus.layer_complete) begin
        got_lc = 1'b1;
        bus.engine_done = 1'b0;
        bus.drain_ack   = 1'b0;
        bus.start       = 1'b0;
        return;
      end
      step();
    end
    bus.engine_done = 1'b0;
    bus.drain_ack   = 1'b0;
    bus.start       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base, dbase, lbase, ebase;
    bit got;

    bus.start = 1'b0; bus.layer_id = '0; bus.engine_done = 1'b0; bus.drain_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_tile_idx", bus.tile_idx, 0);
    check("rst_active_layer", bus.active_layer, 0);
    check("rst_tile_start", bus.tile_start, 0);
    check("rst_drain_req", bus.drain_req, 0);
    check("rst_layer_complete", bus.layer_complete, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Layer 8: two tiles, engine_done 3 cycles late, drain_ack held high.
    base = ts_idx.size(); dbase = dr_rises; lbase = lc_cnt;
    issue_start(4'd8);
    check("l8_lat_tile_start", bus.tile_start, 1);
    check("l8_active_layer", bus.active_layer, 8);
    check("l8_busy", bus.busy, 1);
    serve(3, 1'b1, 1'b0, -1, 200, got);
    check("l8_complete_seen", got, 1);
    step();
    check("l8_tile_count", ts_idx.size() - base, 2);
    check("l8_idx0", ts_idx[base], 0);
    check("l8_idx1", ts_idx[base+1], 1);
    check("l8_drain_windows", dr_rises - dbase, 2);
    check("l8_lc_count", lc_cnt - lbase, 1);
    check("l8_lc_one_cycle", bus.layer_complete, 0);
    check("l8_err_timeout", bus.err_timeout, 0);

    // Layer 4: 16 tiles with zero-wait responders.
    base = ts_idx.size(); lbase = lc_cnt;
    issue_start(4'd4);
    serve(1, 1'b0, 1'b0, -1, 400, got);
    check("l4_complete_seen", got, 1);
    step();
    check("l4_busy_after", bus.busy, 0);
    check("l4_tile_count", ts_idx.size() - base, 16);
    check("l4_lc_count", lc_cnt - lbase, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("l4_idx%0d", i), ts_idx[base+i], i);
      if (i > 0) check($sformatf("l4_period%0d", i), ts_cyc[base+i] - ts_cyc[base+i-1], 4);
    end
    check("l4_lc_after_last", lc_cyc - ts_cyc[base+15], 4);

    // Invalid layer id.
    base = ts_idx.size(); ebase = ei_cnt;
    issue_start(4'd9);
    check("inv_err_pulse", bus.err_invalid, 1);
    check("inv_busy", bus.busy, 0);
    check("inv_no_tile_start", bus.tile_start, 0);
    step();
    check("inv_err_one_cycle", bus.err_invalid, 0);
    check("inv_busy_later", bus.busy, 0);
    step();
    check("inv_err_count", ei_cnt - ebase, 1);
    check("inv_no_tiles", ts_idx.size() - base, 0);

    // Layer 2 with spurious start/engine_done/drain_ack injections.
    base = ts_idx.size(); ebase = ei_cnt; lbase = lc_cnt;
    issue_start(4'd2);
    serve(2, 1'b0, 1'b1, -1, 400, got);
    bus.layer_id = 4'd0;
    check("spur_complete_seen", got, 1);
    check("spur_active_layer", bus.active_layer, 2);
    step();
    check("spur_tile_count", ts_idx.size() - base, 8);
    check("spur_last_idx", ts_idx[base+7], 7);
    check("spur_no_err", ei_cnt - ebase, 0);
    check("spur_lc_count", lc_cnt - lbase, 1);

    // Reset during tile 3 of layer 0.
    issue_start(4'd0);
    serve(1, 1'b0, 1'b0, 3, 200, got);
    check("rst_mid_at_tile3", bus.tile_idx, 3);
    lbase = lc_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_tile_start", bus.tile_start, 0);
    check("rst_mid_tile_idx", bus.tile_idx, 0);
    check("rst_mid_active_layer", bus.active_layer, 0);
    check("rst_mid_drain_req", bus.drain_req, 0);
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_mid_no_lc", lc_cnt - lbase, 0);
    base = ts_idx.size();
    issue_start(4'd0);
    check("restart_tile_start", bus.tile_start, 1);
    check("restart_tile_idx", bus.tile_idx, 0);
    serve(1, 1'b0, 1'b0, -1, 200, got);
    check("restart_complete_seen", got, 1);
    step();
    check("restart_tile_count", ts_idx.size() - base, 4);

`ifdef ONEDCONV_EXEC_WATCHDOG_EN
    // Watchdog with WDT_CYCLES = 16: engine never answers.
    lbase = lc_cnt;
    issue_start(4'd1);
    step();
    check("wdt_clear_at_entry", bus.err_timeout, 0);
    repeat (15) step();
    check("wdt_not_yet", bus.err_timeout, 0);
    check("wdt_still_busy", bus.busy, 1);
    step();
    check("wdt_fired", bus.err_timeout, 1);
    check("wdt_idle", bus.busy, 0);
    step();
    check("wdt_no_lc", lc_cnt - lbase, 0);
    check("wdt_sticky", bus.err_timeout, 1);
    issue_start(4'd1);
    check("wdt_cleared_by_start", bus.err_timeout, 0);
    serve(1, 1'b0, 1'b0, -1, 200, got);
    check("wdt_recover_complete", got, 1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
